// File: rtl/chip_invaders_pkg.sv
// Shared game-logic types and constants: shot FSM states, position width,
// LFSR seed/taps and the level-scaled cooldown reload.
package chip_invaders_pkg;

  typedef enum logic [1:0] {COOLDOWN, SCAN, OFFER} shot_state_t;

  localparam int          POS_W     = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as 0-based bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // A negative or sub-floor difference both clamp to the floor.
  function automatic logic [POS_W-1:0] cooldown_reload(input logic [3:0] lvl,
                                                       input int base,
                                                       input int step,
                                                       input int floor_v);
    int dec, diff;
    dec  = int'(lvl) * step;
    diff = base - dec;
    if (diff < floor_v) cooldown_reload = POS_W'(floor_v);
    else                cooldown_reload = POS_W'(diff);
  endfunction

endpackage

// File: rtl/alien_shot_scheduler_if.sv
// Shot spawn channel from the scheduler (master) to the alien bullet pool (slave).
interface alien_shot_scheduler_if #(
  parameter int NUM_COLS = 5
);
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  logic                                shot_valid;
  logic                                shot_ready;
  logic [chip_invaders_pkg::POS_W-1:0] shot_x;
  logic [chip_invaders_pkg::POS_W-1:0] shot_y;
  logic [COL_W-1:0]                    shot_col;

  modport master (output shot_valid, shot_x, shot_y, shot_col, input  shot_ready);
  modport slave  (input  shot_valid, shot_x, shot_y, shot_col, output shot_ready);
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR shared by the random game events.
module lfsr16
  import chip_invaders_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= LFSR_SEED;
    else        q <= {q[14:0], ^(q & LFSR_TAPS)};
  end
endmodule

// File: rtl/alien_shot_scheduler.sv
// Alien fire scheduler: level-scaled cooldown, random-start column scan and a
// single registered shot offer, with a cap on alien shots in flight.
module alien_shot_scheduler
  import chip_invaders_pkg::*;
#(
  parameter int NUM_ROWS      = 3,
  parameter int NUM_COLS      = 5,
  parameter int BASE_COOLDOWN = 120,
  parameter int LEVEL_STEP    = 8,
  parameter int MIN_COOLDOWN  = 16,
  parameter int MAX_SHOTS     = 3,
  parameter int SHOT_OFFSET_X = 8,
  parameter int SHOT_OFFSET_Y = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        fire_enable,
  input  logic [3:0]                                  level,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]             armed_matrix,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0][POS_W-1:0]  alien_positions_x,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0][POS_W-1:0]  alien_positions_y,
  input  logic                                        shot_retired,
  output logic [2:0]                                  shots_in_flight,
  alien_shot_scheduler_if.master                      shot
);
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  shot_state_t      state_q;
  logic [15:0]      cnt_q, lfsr_q, cd_reload;
  logic [COL_W-1:0] scan_col_q, scanned_q, col_q, start_col, next_col;
  logic [POS_W-1:0] x_q, y_q;
  logic             valid_q;
  logic [2:0]       inflight_q;
  logic             col_hit, handshake, retire, cd_run;
  logic [ROW_W-1:0] hit_row;
  logic             unused_lfsr_hi;

  lfsr16 u_lfsr (.clk(clk), .rst_n(rst_n), .q(lfsr_q));

  assign cd_reload      = cooldown_reload(level, BASE_COOLDOWN, LEVEL_STEP, MIN_COOLDOWN);
  assign start_col      = COL_W'(32'(lfsr_q[7:0]) % NUM_COLS);
  assign unused_lfsr_hi = ^lfsr_q[15:8];
  assign next_col       = (scan_col_q == COL_W'(NUM_COLS-1)) ? '0 : scan_col_q + 1'b1;
  assign handshake      = valid_q && shot.shot_ready;
  assign retire         = shot_retired && (inflight_q != 3'd0);
  assign cd_run         = fire_enable && (inflight_q < 3'(MAX_SHOTS));

  // Later rows overwrite earlier ones, so a malformed column yields its highest row.
  always_comb begin
    col_hit = 1'b0;
    hit_row = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (armed_matrix[r][scan_col_q]) begin
        col_hit = 1'b1;
        hit_row = ROW_W'(r);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COOLDOWN;
      cnt_q      <= 16'(BASE_COOLDOWN);
      scan_col_q <= '0;
      scanned_q  <= '0;
      valid_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      col_q      <= '0;
      inflight_q <= '0;
    end else begin
      if (handshake && !retire && (inflight_q < 3'(MAX_SHOTS))) inflight_q <= inflight_q + 3'd1;
      else if (retire && !handshake)                            inflight_q <= inflight_q - 3'd1;

      case (state_q)
        COOLDOWN: if (cd_run) begin
          cnt_q <= cnt_q - 16'd1;
          if (cnt_q <= 16'd1) begin
            state_q    <= SCAN;
            scan_col_q <= start_col;
            scanned_q  <= '0;
          end
        end
        SCAN: begin
          if (!fire_enable) begin
            state_q <= COOLDOWN;
            cnt_q   <= cd_reload;
          end else if (col_hit) begin
            x_q     <= alien_positions_x[hit_row][scan_col_q] + POS_W'(SHOT_OFFSET_X);
            y_q     <= alien_positions_y[hit_row][scan_col_q] + POS_W'(SHOT_OFFSET_Y);
            col_q   <= scan_col_q;
            valid_q <= 1'b1;
            state_q <= OFFER;
          end else if (scanned_q == COL_W'(NUM_COLS-1)) begin
            state_q <= COOLDOWN;
            cnt_q   <= cd_reload;
          end else begin
            scan_col_q <= next_col;
            scanned_q  <= scanned_q + 1'b1;
          end
        end
        // Handshake takes priority; a disabled, unaccepted offer is withdrawn.
        OFFER: if (shot.shot_ready || !fire_enable) begin
          valid_q <= 1'b0;
          state_q <= COOLDOWN;
          cnt_q   <= cd_reload;
        end
        default: state_q <= COOLDOWN;
      endcase
    end
  end

  assign shot.shot_valid = valid_q;
  assign shot.shot_x     = x_q;
  assign shot.shot_y     = y_q;
  assign shot.shot_col   = col_q;
  assign shots_in_flight = inflight_q;
endmodule

// File: tb/tb_alien_shot_scheduler.sv
// Scenario bench for alien_shot_scheduler against a transaction-level model of
// cooldown length, random start column and first-hit scan.
module tb_alien_shot_scheduler;
  localparam int NR = 3;
  localparam int NC = 5;

  logic clk = 1'b0, rst_n = 1'b1, fire_enable = 1'b0, shot_retired = 1'b0;
  logic [3:0] level = 4'd0;
  logic [NR-1:0][NC-1:0] armed;
  logic [NR-1:0][NC-1:0][15:0] posx, posy;
  logic [2:0] shots_in_flight;
  int total = 0, bad = 0, edges = 0;
  int exp_lat, exp_col;
  logic [15:0] exp_x, exp_y;

  alien_shot_scheduler_if #(.NUM_COLS(NC)) sif();

  alien_shot_scheduler #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .BASE_COOLDOWN(10), .LEVEL_STEP(2),
    .MIN_COOLDOWN(4), .MAX_SHOTS(2), .SHOT_OFFSET_X(8), .SHOT_OFFSET_Y(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fire_enable(fire_enable), .level(level),
    .armed_matrix(armed), .alien_positions_x(posx), .alien_positions_y(posy),
    .shot_retired(shot_retired), .shots_in_flight(shots_in_flight), .shot(sif)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; the LFSR has stepped exactly this many times.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return v;
  endfunction

  function automatic int cd_of(input int lv);
    int v;
    v = 10 - 2 * lv;
    return (v < 4) ? 4 : v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int lv);
    @(negedge clk);
    rst_n = 1'b0;
    tick(2);
    level = 4'(lv);
    fire_enable = 1'b1;
    shot_retired = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic rand_matrix(input bit nonempty);
    logic [2:0] cb;
    for (int c = 0; c < NC; c++) begin
      cb = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
      for (int r = 0; r < NR; r++) armed[r][c] = cb[r];
    end
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) begin
        posx[r][c] = 16'($urandom);
        posy[r][c] = 16'($urandom);
      end
    if (nonempty && armed == '0) armed[$urandom_range(0, 2)][$urandom_range(0, 4)] = 1'b1;
  endtask

  // remaining = enabled cycles still needed at this negedge before SCAN is entered.
  task automatic predict(input int remaining);
    logic [15:0] l;
    logic [NR-1:0] cb;
    int start, c;
    l = lfsr_at(edges + remaining - 1);
    start = int'(l[7:0]) % NC;
    exp_lat = -1; exp_col = 0; exp_x = 16'd0; exp_y = 16'd0;
    for (int i = 0; i < NC; i++) begin
      c = (start + i) % NC;
      for (int r = 0; r < NR; r++) cb[r] = armed[r][c];
      if (exp_lat < 0 && cb != '0) begin
        exp_lat = remaining + i + 1;
        exp_col = c;
        for (int r = 0; r < NR; r++)
          if (cb[r]) begin
            exp_x = posx[r][c] + 16'd8;
            exp_y = posy[r][c] + 16'd16;
          end
      end
    end
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (sif.shot_valid === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    total++; if (sif.shot_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", sif.shot_valid); end
    total++; if (sif.shot_x !== 16'd0) begin bad++; $display("FAIL reset_x got=%0d exp=0", sif.shot_x); end
    total++; if (sif.shot_y !== 16'd0) begin bad++; $display("FAIL reset_y got=%0d exp=0", sif.shot_y); end
    total++; if (sif.shot_col !== 3'd0) begin bad++; $display("FAIL reset_col got=%0d exp=0", sif.shot_col); end
    total++; if (shots_in_flight !== 3'd0) begin bad++; $display("FAIL reset_inflight got=%0d exp=0", shots_in_flight); end
  endtask

  task automatic test_cooldown();
    int n;
    rand_matrix(0);
    armed = '0; armed[2][0] = 1'b1; posx[2][0] = 16'd100; posy[2][0] = 16'd114;
    sif.shot_ready = 1'b1;
    do_reset(0);
    predict(10); wait_valid(200, n);
    total++; if (n !== exp_lat) begin bad++; $display("FAIL cd_latency got=%0d exp=%0d", n, exp_lat); end
    total++; if (sif.shot_x !== 16'd108) begin bad++; $display("FAIL cd_x got=%0d exp=108", sif.shot_x); end
    total++; if (sif.shot_y !== 16'd130) begin bad++; $display("FAIL cd_y got=%0d exp=130", sif.shot_y); end
    total++; if (sif.shot_col !== 3'd0) begin bad++; $display("FAIL cd_col got=%0d exp=0", sif.shot_col); end
    tick(1);
    total++; if (sif.shot_valid !== 1'b0) begin bad++; $display("FAIL cd_valid_drop got=%0b exp=0", sif.shot_valid); end
    total++; if (shots_in_flight !== 3'd1) begin bad++; $display("FAIL cd_inflight got=%0d exp=1", shots_in_flight); end
    predict(10); wait_valid(200, n);
    total++; if (n !== exp_lat) begin bad++; $display("FAIL cd_latency2 got=%0d exp=%0d", n, exp_lat); end
  endtask

  task automatic test_level_floor();
    int n;
    rand_matrix(1);
    sif.shot_ready = 1'b1;
    do_reset(7);
    predict(10); wait_valid(200, n);
    total++; if (n !== exp_lat) begin bad++; $display("FAIL floor_first got=%0d exp=%0d", n, exp_lat); end
    tick(1);
    predict(4); wait_valid(200, n);
    total++; if (n !== exp_lat) begin bad++; $display("FAIL floor_reload got=%0d exp=%0d", n, exp_lat); end
    total++; if (sif.shot_x !== exp_x || sif.shot_y !== exp_y || sif.shot_col !== 3'(exp_col)) begin
      bad++; $display("FAIL floor_payload got=%0d,%0d,%0d exp=%0d,%0d,%0d", sif.shot_x, sif.shot_y, sif.shot_col, exp_x, exp_y, exp_col);
    end
  endtask

  task automatic test_empty();
    int n, lv, highs;
    lv = $urandom_range(0, 7);
    armed = '0;
    sif.shot_ready = 1'b1;
    do_reset(lv);
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (sif.shot_valid !== 1'b0) highs++;
    end
    total++; if (highs !== 0) begin bad++; $display("FAIL empty_valid got=%0d exp=0", highs); end
    rand_matrix(1);
    predict(cd_of(lv) - 1); wait_valid(200, n);
    total++; if (n !== exp_lat) begin bad++; $display("FAIL empty_scan_len got=%0d exp=%0d", n, exp_lat); end
    total++; if (sif.shot_col !== 3'(exp_col)) begin bad++; $display("FAIL empty_col got=%0d exp=%0d", sif.shot_col, exp_col); end
  endtask

  task automatic test_backpressure();
    int n, errs;
    rand_matrix(1);
    sif.shot_ready = 1'b0;
    do_reset(0);
    predict(10); wait_valid(200, n);
    total++; if (n !== exp_lat) begin bad++; $display("FAIL bp_latency got=%0d exp=%0d", n, exp_lat); end
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      rand_matrix(1);
      tick(1);
      if (sif.shot_valid !== 1'b1 || sif.shot_x !== exp_x || sif.shot_y !== exp_y ||
          sif.shot_col !== 3'(exp_col) || shots_in_flight !== 3'd0) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL bp_hold got=%0d exp=0", errs); end
    sif.shot_ready = 1'b1;
    tick(1);
    total++; if (sif.shot_valid !== 1'b0 || shots_in_flight !== 3'd1) begin
      bad++; $display("FAIL bp_handshake got=%0b/%0d exp=0/1", sif.shot_valid, shots_in_flight);
    end
    predict(10); wait_valid(200, n);
    total++; if (n !== exp_lat) begin bad++; $display("FAIL bp_second got=%0d exp=%0d", n, exp_lat); end
    tick(1);
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (sif.shot_valid !== 1'b0 || shots_in_flight !== 3'd2) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL bp_freeze got=%0d exp=0", errs); end
    shot_retired = 1'b1; tick(1); shot_retired = 1'b0;
    total++; if (shots_in_flight !== 3'd1) begin bad++; $display("FAIL bp_retire got=%0d exp=1", shots_in_flight); end
    predict(10); wait_valid(200, n);
    total++; if (n !== exp_lat) begin bad++; $display("FAIL bp_resume got=%0d exp=%0d", n, exp_lat); end
  endtask

  task automatic test_simultaneous();
    int n;
    rand_matrix(1);
    sif.shot_ready = 1'b1;
    do_reset(0);
    predict(10); wait_valid(200, n);
    tick(1);
    total++; if (shots_in_flight !== 3'd1) begin bad++; $display("FAIL sim_first got=%0d exp=1", shots_in_flight); end
    predict(10); wait_valid(200, n);
    total++; if (n !== exp_lat) begin bad++; $display("FAIL sim_latency got=%0d exp=%0d", n, exp_lat); end
    shot_retired = 1'b1; tick(1); shot_retired = 1'b0;
    total++; if (shots_in_flight !== 3'd1) begin bad++; $display("FAIL sim_both got=%0d exp=1", shots_in_flight); end
    shot_retired = 1'b1; tick(1); shot_retired = 1'b0;
    total++; if (shots_in_flight !== 3'd0) begin bad++; $display("FAIL sim_retire got=%0d exp=0", shots_in_flight); end
    shot_retired = 1'b1; tick(1); shot_retired = 1'b0;
    total++; if (shots_in_flight !== 3'd0) begin bad++; $display("FAIL sim_retire_zero got=%0d exp=0", shots_in_flight); end
  endtask

  task automatic test_abort();
    int n, highs;
    rand_matrix(1);
    sif.shot_ready = 1'b0;
    do_reset(0);
    predict(10); wait_valid(200, n);
    total++; if (n !== exp_lat) begin bad++; $display("FAIL abort_latency got=%0d exp=%0d", n, exp_lat); end
    fire_enable = 1'b0;
    tick(1);
    total++; if (sif.shot_valid !== 1'b0) begin bad++; $display("FAIL abort_drop got=%0b exp=0", sif.shot_valid); end
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (sif.shot_valid !== 1'b0 || shots_in_flight !== 3'd0) highs++;
    end
    total++; if (highs !== 0) begin bad++; $display("FAIL abort_idle got=%0d exp=0", highs); end
    fire_enable = 1'b1;
    predict(10); wait_valid(200, n);
    total++; if (n !== exp_lat) begin bad++; $display("FAIL abort_reload got=%0d exp=%0d", n, exp_lat); end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    rand_matrix(1);
    sif.shot_ready = 1'b1;
    do_reset(0);
    predict(10); wait_valid(200, n);
    tick(1);
    armed = '0;
    tick(12);
    #2 rst_n = 1'b0;
    #1;
    total++; if (sif.shot_valid !== 1'b0 || sif.shot_x !== 16'd0 || sif.shot_y !== 16'd0 ||
                 sif.shot_col !== 3'd0 || shots_in_flight !== 3'd0) begin
      bad++; $display("FAIL midscan_reset got=%0b,%0d,%0d,%0d,%0d exp=0,0,0,0,0",
                      sif.shot_valid, sif.shot_x, sif.shot_y, sif.shot_col, shots_in_flight);
    end
  endtask

  task automatic test_random_stream();
    int n, lv, rem, d;
    sif.shot_ready = 1'b0;
    rand_matrix(1);
    lv = $urandom_range(0, 7);
    do_reset(lv);
    rem = 10;
    for (int k = 0; k < 12; k++) begin
      predict(rem); wait_valid(300, n);
      total++; if (n !== exp_lat) begin bad++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", k, n, exp_lat); end
      d = $urandom_range(0, 3);
      tick(d);
      total++; if (sif.shot_valid !== 1'b1 || sif.shot_x !== exp_x || sif.shot_y !== exp_y || sif.shot_col !== 3'(exp_col)) begin
        bad++; $display("FAIL rnd_payload[%0d] got=%0b,%0d,%0d,%0d exp=1,%0d,%0d,%0d", k, sif.shot_valid,
                        sif.shot_x, sif.shot_y, sif.shot_col, exp_x, exp_y, exp_col);
      end
      lv = $urandom_range(0, 7);
      level = 4'(lv);
      rand_matrix(1);
      sif.shot_ready = 1'b1; tick(1); sif.shot_ready = 1'b0;
      total++; if (shots_in_flight !== 3'd1) begin bad++; $display("FAIL rnd_inflight[%0d] got=%0d exp=1", k, shots_in_flight); end
      shot_retired = 1'b1; tick(1); shot_retired = 1'b0;
      total++; if (shots_in_flight !== 3'd0) begin bad++; $display("FAIL rnd_retire[%0d] got=%0d exp=0", k, shots_in_flight); end
      rem = cd_of(lv) - 1;
    end
  endtask

  initial begin
    armed = '0; posx = '0; posy = '0;
    sif.shot_ready = 1'b0;
    test_reset();
    test_cooldown();
    test_level_floor();
    test_empty();
    test_backpressure();
    test_simultaneous();
    test_abort();
    test_reset_mid_scan();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
